road_speed_scheduler: RTL and testbench



---
 rtl/road_speed_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_road_speed_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/road_speed_scheduler.sv
// ============================================================================
// Module   : road_speed_scheduler
// Purpose  : Per-frame player speed / road scroll controller for Road Fighter.
//            Samples keys and collision events once per video frame. It
//            produces the signed player speed, the scroll offset and the
//            crash-recovery sequencing that all movers share.
// Options  : ROAD_SPEED_TURBO_EN adds a turbo_key input. The turbo key gives
//            a doubled accelerate step and a raised speed ceiling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module road_speed_scheduler #(
  parameter int MAX_SPEED    = 400,
  parameter int ACCEL_STEP   = 4,
  parameter int BRAKE_STEP   = 12,
  parameter int DRAG_STEP    = 1,
  parameter int CRASH_RECOIL = 64,
  parameter int SPIN_FRAMES  = 60,
  parameter int FRAC_BITS    = 6
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               game_enable,
  input  logic               accel_key,
  input  logic               brake_key,
  input  logic               crash,
`ifdef ROAD_SPEED_TURBO_EN
  input  logic               turbo_key,
`endif
  output logic signed [10:0] speed,
  output logic        [10:0] road_offset,
  output logic               crash_active,
  output logic               frame_tick
);

  localparam int c_acc_w = 11 + FRAC_BITS;
  localparam int c_cnt_w = (SPIN_FRAMES > 1) ? $clog2(SPIN_FRAMES) : 1;

  localparam logic signed [11:0] c_zero   = '0;
  localparam logic signed [11:0] c_max    = 12'(MAX_SPEED);
  localparam logic signed [11:0] c_accel  = 12'(ACCEL_STEP);
  localparam logic signed [11:0] c_brake  = 12'(BRAKE_STEP);
  localparam logic signed [11:0] c_drag   = 12'(DRAG_STEP);
  localparam logic signed [11:0] c_recoil = 12'(CRASH_RECOIL);
`ifdef ROAD_SPEED_TURBO_EN
  localparam logic signed [11:0] c_tmax   = 12'(MAX_SPEED + MAX_SPEED / 4);
  localparam logic signed [11:0] c_taccel = 12'(2 * ACCEL_STEP);
`endif
  localparam logic [c_cnt_w-1:0] c_spin_init = c_cnt_w'(SPIN_FRAMES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CRASH = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [10:0]       r_speed, w_speed_nxt;
  logic        [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic        [c_acc_w-1:0] r_acc, w_acc_nxt;
  logic                     r_pend, r_crash_act, r_tick;
  logic signed [11:0]       w_sp12, w_tmp;
  logic                     w_crash;

  assign w_sp12  = {r_speed[10], r_speed};
  // A crash pulse coincident with the frame strobe counts for that frame.
  assign w_crash = r_pend | crash;
  // The added term is the speed after this frame's update; it is zero in IDLE.
  assign w_acc_nxt = r_acc + {{(c_acc_w-11){w_speed_nxt[10]}}, w_speed_nxt};

  // Latch crash events between frames; discard them while already spinning.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pend <= 1'b0;
    end else if (startOfFrame) begin
      r_pend <= 1'b0;
    end else if (crash && (r_state != ST_CRASH)) begin
      r_pend <= 1'b1;
    end
  end

  // Frame-rate state, speed, spin timer and scroll registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_speed     <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_crash_act <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_tick <= startOfFrame;
      if (startOfFrame) begin
        r_state     <= w_state_nxt;
        r_speed     <= w_speed_nxt;
        r_cnt       <= w_cnt_nxt;
        r_acc       <= w_acc_nxt;
        r_crash_act <= (w_state_nxt == ST_CRASH);
      end
    end
  end

  // Next-state and next-speed rules evaluated for the coming frame.
  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_speed;
    w_cnt_nxt   = r_cnt;
    w_tmp       = w_sp12;
    if (!game_enable) begin
      w_state_nxt = ST_IDLE;
      w_speed_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_speed_nxt = '0;
          if (accel_key) begin
            w_tmp = c_accel;
            if (w_tmp > c_max) w_tmp = c_max;
            w_speed_nxt = w_tmp[10:0];
            w_state_nxt = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (w_crash) begin
            w_tmp       = c_zero - c_recoil;
            w_speed_nxt = w_tmp[10:0];
            w_cnt_nxt   = c_spin_init;
            w_state_nxt = ST_CRASH;
          end else begin
            if (brake_key) begin
              w_tmp = w_sp12 - c_brake;
              if (w_tmp < c_zero) w_tmp = c_zero;
`ifdef ROAD_SPEED_TURBO_EN
            end else if (accel_key && turbo_key) begin
              w_tmp = w_sp12 + c_taccel;
              if (w_tmp > c_tmax) w_tmp = c_tmax;
            end else if (w_sp12 > c_max) begin
              // Turbo released: bleed off the excess toward the normal ceiling.
              w_tmp = w_sp12 - c_drag;
              if (w_tmp < c_max) w_tmp = c_max;
`endif
            end else if (accel_key) begin
              w_tmp = w_sp12 + c_accel;
              if (w_tmp > c_max) w_tmp = c_max;
            end else begin
              w_tmp = w_sp12 - c_drag;
              if (w_tmp < c_zero) w_tmp = c_zero;
            end
            w_speed_nxt = w_tmp[10:0];
            if ((w_tmp == c_zero) && !accel_key) w_state_nxt = ST_IDLE;
          end
        end
        ST_CRASH: begin
          if (r_cnt == '0) begin
            w_speed_nxt = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - c_cnt_one;
            if (w_sp12 < c_zero) begin
              w_tmp = w_sp12 + c_drag;
              if (w_tmp > c_zero) w_tmp = c_zero;
            end else if (w_sp12 > c_zero) begin
              w_tmp = w_sp12 - c_drag;
              if (w_tmp < c_zero) w_tmp = c_zero;
            end
            w_speed_nxt = w_tmp[10:0];
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_speed_nxt = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign speed        = r_speed;
  assign road_offset  = r_acc[c_acc_w-1:FRAC_BITS];
  assign crash_active = r_crash_act;
  assign frame_tick   = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_road_speed_scheduler.sv
// ============================================================================
// Module   : tb_road_speed_scheduler
// Purpose  : Self-checking bench for road_speed_scheduler. Directed scenarios
//            plus randomized key/crash/frame traffic are compared against a
//            frame-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_road_speed_scheduler;

  localparam int MAX_SPEED    = 400;
  localparam int ACCEL_STEP   = 4;
  localparam int BRAKE_STEP   = 12;
  localparam int DRAG_STEP    = 1;
  localparam int CRASH_RECOIL = 64;
  localparam int SPIN_FRAMES  = 60;
  localparam int FRAC_BITS    = 6;
  localparam int ACC_MOD      = 1 << (11 + FRAC_BITS);
`ifdef ROAD_SPEED_TURBO_EN
  localparam bit TURBO = 1'b1;
`else
  localparam bit TURBO = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN, startOfFrame, game_enable, accel_key, brake_key, crash;
`ifdef ROAD_SPEED_TURBO_EN
  logic turbo_key;
`endif
  logic signed [10:0] speed;
  logic        [10:0] road_offset;
  logic               crash_active, frame_tick;

  always #5 clk = ~clk;

  road_speed_scheduler dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .game_enable  (game_enable),
    .accel_key    (accel_key),
    .brake_key    (brake_key),
    .crash        (crash),
`ifdef ROAD_SPEED_TURBO_EN
    .turbo_key    (turbo_key),
`endif
    .speed        (speed),
    .road_offset  (road_offset),
    .crash_active (crash_active),
    .frame_tick   (frame_tick)
  );

  // Reference model: mode 0 = idle, 1 = driving, 2 = spinning after a crash.
  int m_mode, m_spd, m_cnt, m_pos, m_pend, m_tick;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_spd = 0; m_cnt = 0; m_pos = 0; m_pend = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit sof, input bit en, input bit acc,
                            input bit brk, input bit cr, input bit trb);
    bit crash_now;
    if (sof) begin
      crash_now = (m_pend != 0) || cr;
      if (!en) begin
        m_mode = 0; m_spd = 0; m_cnt = 0;
      end else if (m_mode == 0) begin
        if (acc) begin
          m_mode = 1;
          m_spd  = imin(ACCEL_STEP, MAX_SPEED);
        end else begin
          m_spd = 0;
        end
      end else if (m_mode == 1) begin
        if (crash_now) begin
          m_mode = 2; m_spd = -CRASH_RECOIL; m_cnt = SPIN_FRAMES - 1;
        end else begin
          if (brk)                       m_spd = imax(m_spd - BRAKE_STEP, 0);
          else if (TURBO && acc && trb)  m_spd = imin(m_spd + 2 * ACCEL_STEP, MAX_SPEED + MAX_SPEED / 4);
          else if (m_spd > MAX_SPEED)    m_spd = imax(m_spd - DRAG_STEP, MAX_SPEED);
          else if (acc)                  m_spd = imin(m_spd + ACCEL_STEP, MAX_SPEED);
          else                           m_spd = imax(m_spd - DRAG_STEP, 0);
          if (m_spd == 0 && !acc) m_mode = 0;
        end
      end else begin
        if (m_cnt == 0) begin
          m_spd = 0; m_mode = 0;
        end else begin
          m_cnt--;
          if (m_spd < 0)      m_spd = imin(m_spd + DRAG_STEP, 0);
          else if (m_spd > 0) m_spd = imax(m_spd - DRAG_STEP, 0);
        end
      end
      m_pos  = (m_pos + m_spd) & (ACC_MOD - 1);
      m_pend = 0;
      m_tick = 1;
    end else begin
      m_tick = 0;
      if (cr && m_mode != 2) m_pend = 1;
    end
  endtask

  task automatic compare_all();
    check("speed",        int'(speed),        m_spd);
    check("road_offset",  int'(road_offset),  m_pos >> FRAC_BITS);
    check("crash_active", int'(crash_active), (m_mode == 2) ? 1 : 0);
    check("frame_tick",   int'(frame_tick),   m_tick);
  endtask

  // One clock: drive inputs, clock the DUT and the model, then compare.
  task automatic cyc(input bit sof, input bit en, input bit acc,
                     input bit brk, input bit cr, input bit trb);
    startOfFrame = sof; game_enable = en; accel_key = acc;
    brake_key = brk; crash = cr;
`ifdef ROAD_SPEED_TURBO_EN
    turbo_key = trb;
`endif
    @(posedge clk);
    model_step(sof, en, acc, brk, cr, trb);
    #1;
    compare_all();
  endtask

  // A frame is one strobe cycle followed by two quiet cycles.
  task automatic frames(input int n, input bit en, input bit acc,
                        input bit brk, input bit trb);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, en, acc, brk, 1'b0, trb);
      cyc(1'b0, en, acc, brk, 1'b0, trb);
      cyc(1'b0, en, acc, brk, 1'b0, trb);
    end
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic apply_reset();
    resetN = 1'b0;
    #1;
    model_reset();
    check("rst_speed",  int'(speed),        0);
    check("rst_offset", int'(road_offset),  0);
    check("rst_crash",  int'(crash_active), 0);
    check("rst_tick",   int'(frame_tick),   0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    startOfFrame = 0; game_enable = 0; accel_key = 0; brake_key = 0; crash = 0;
`ifdef ROAD_SPEED_TURBO_EN
    turbo_key = 0;
`endif
    apply_reset();

    // Acceleration ramp to saturation.
    frames(110, 1, 1, 0, 0);
    check("saturate", int'(speed), MAX_SPEED);

    // Brake with accel held: brake wins, floors at zero.
    frames(34, 1, 1, 1, 0);
    check("brake_floor", int'(speed), 0);
    frames(2, 1, 0, 0, 0);

    // Build to 200, crash mid-frame, keys mashed during the spin.
    frames(50, 1, 1, 0, 0);
    check("speed_200", int'(speed), 200);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    check("recoil", int'(speed), -CRASH_RECOIL);
    check("crash_on", int'(crash_active), 1);
    for (int f = 0; f < 61; f++) begin
      cyc(1, 1, f[0], f[1], 0, 0);
      cyc(0, 1, f[0], f[1], (f == 20) ? 1'b1 : 1'b0, 0);
      cyc(0, 1, f[0], f[1], 0, 0);
    end
    check("spin_done_speed", int'(speed), 0);
    check("spin_done_flag",  int'(crash_active), 0);

    // Backward wrap from offset 0, crash coincident with the frame strobe.
    apply_reset();
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 0);
    check("wrap", int'(road_offset), 2047);
    frames(62, 1, 0, 0, 0);

    // game_enable drop at speed 300.
    frames(75, 1, 1, 0, 0);
    check("speed_300", int'(speed), 300);
    frames(3, 0, 1, 0, 0);
    check("disable_speed", int'(speed), 0);

    // Asynchronous reset in the middle of a spin.
    frames(20, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 1, 0);
    frames(5, 1, 1, 0, 0);
    apply_reset();

`ifdef ROAD_SPEED_TURBO_EN
    frames(70, 1, 1, 0, 1);
    check("turbo_max", int'(speed), MAX_SPEED + MAX_SPEED / 4);
    frames(110, 1, 1, 0, 0);
    check("turbo_decay", int'(speed), MAX_SPEED);
`endif

    // Randomized traffic in segments with different key biases.
    for (int seg = 0; seg < 30; seg++) begin
      int kind;
      kind = $urandom_range(0, 3);
      for (int i = 0; i < 120; i++) begin
        bit sof, en, acc, brk, cr, trb;
        sof = ($urandom_range(0, 2) == 0);
        en  = ($urandom_range(0, 79) != 0);
        case (kind)
          0:       begin acc = 1'b1; brk = ($urandom_range(0, 19) == 0); end
          1:       begin acc = $urandom_range(0, 1); brk = ($urandom_range(0, 2) == 0); end
          2:       begin acc = ($urandom_range(0, 9) < 7); brk = ($urandom_range(0, 9) == 0); end
          default: begin acc = 1'b0; brk = 1'b0; end
        endcase
        cr  = ($urandom_range(0, 99) == 0);
        trb = $urandom_range(0, 1);
        cyc(sof, en, acc, brk, cr, trb);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
